// File: rtl/tcam_upd_ctrl.sv
// TCAM update controller: rewrites one entry's bit in every (subword, value) word of its layer
// by read-modify-write, yielding to lookups in RD. Macro TCAM_UPD_WRSKIP_EN skips no-op writes.
module tcam_upd_ctrl #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 36,
    parameter int L     = 4,
    parameter int N     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [$clog2(DEPTH)-1:0] upd_addr,
    input  logic [WIDTH-1:0]         upd_patt,
    input  logic [WIDTH-1:0]         upd_mask,
    input  logic                     upd_del,
    output logic                     upd_busy,
    output logic                     upd_done,
    input  logic                     lk_valid,
    output logic                     lk_ready,
    input  logic [WIDTH-1:0]         lk_patt,
    output logic [L*N-1:0]           ram_wen,
    output logic [N*(WIDTH/N)-1:0]   ram_addr,
    output logic [DEPTH/L-1:0]       ram_din,
    input  logic [L*N*(DEPTH/L)-1:0] ram_dout
);
    localparam int SW = WIDTH / N;
    localparam int SA = DEPTH / L;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (SA > 1) ? $clog2(SA) : 1;
    localparam int KW = (L * N > 1) ? $clog2(L * N) : 1;

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [WIDTH-1:0] patt_q;
    logic [WIDTH-1:0] mask_q;
    logic            del_q;
    logic [JW-1:0]   j_q;
    logic [SW-1:0]   v_q;
    logic [L*N-1:0]  wen_q;
    logic [SA-1:0]   din_q;
    logic            done_q;

    logic [LW-1:0]   layer;
    logic [BW-1:0]   bidx;
    logic [KW-1:0]   sel;
    logic [SA-1:0]   cur_word;
    logic [SA-1:0]   new_word;
    logic [SW-1:0]   patt_j;
    logic [SW-1:0]   mask_j;
    logic            hit;
    logic            new_bit;
    logic [L*N-1:0]  wen_d;
    logic            lk_grant;
    logic            active;

    assign layer = LW'({1'b0, addr_q} / (AW+1)'(SA));
    assign bidx  = BW'({1'b0, addr_q} % (AW+1)'(SA));
    assign sel   = KW'(layer) * KW'(N) + KW'(j_q);

    always_comb begin
        cur_word       = ram_dout[sel*SA +: SA];
        patt_j         = patt_q[j_q*SW +: SW];
        mask_j         = mask_q[j_q*SW +: SW];
        hit            = (((v_q ^ patt_j) & ~mask_j) == '0);
        new_bit        = hit & ~del_q;
        new_word       = cur_word;
        new_word[bidx] = new_bit;
        wen_d          = '0;
        wen_d[sel]     = 1'b1;
`ifdef TCAM_UPD_WRSKIP_EN
        if (new_bit == cur_word[bidx]) wen_d = '0;
`endif
    end

    // Everything combinational on the outputs is gated by rst_n so reset forces quiet outputs.
    always_comb begin
        lk_grant  = rst_n && lk_valid && (state_q == IDLE || state_q == RD);
        active    = rst_n && (state_q != IDLE);
        lk_ready  = lk_grant;
        upd_ready = rst_n && !lk_valid && (state_q == IDLE);
        upd_busy  = active;
        upd_done  = done_q;
        ram_wen   = (rst_n && state_q == WR) ? wen_q : '0;
        ram_din   = (rst_n && state_q == WR) ? din_q : '0;
        ram_addr  = '0;
        if (lk_grant) ram_addr = lk_patt;
        else if (active) ram_addr[j_q*SW +: SW] = v_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            patt_q  <= '0;
            mask_q  <= '0;
            del_q   <= 1'b0;
            j_q     <= '0;
            v_q     <= '0;
            wen_q   <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (upd_valid && upd_ready) begin
                    addr_q  <= upd_addr;
                    patt_q  <= upd_patt;
                    mask_q  <= upd_mask;
                    del_q   <= upd_del;
                    j_q     <= '0;
                    v_q     <= '0;
                    state_q <= RD;
                end
                RD: if (!lk_valid) state_q <= CAP;
                // Write word and enable are registered here so WR drives them straight from flops.
                CAP: begin
                    din_q   <= new_word;
                    wen_q   <= wen_d;
                    state_q <= WR;
                end
                WR: begin
                    v_q <= v_q + 1'b1;
                    if (v_q == '1) begin
                        j_q <= j_q + 1'b1;
                        if (j_q == JW'(N - 1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD;
                        end
                    end else begin
                        state_q <= RD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tcam_upd_ctrl.sv
// Directed self-checking bench for tcam_upd_ctrl with a 16-bank RAM model (1-cycle read).
// Expectations follow the TCAM_UPD_WRSKIP_EN build setting for write-cycle counts.
module tb_tcam_upd_ctrl;
    localparam int SW = 9;
    localparam int SA = 128;
    localparam int NB = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [8:0]      upd_addr = '0;
    logic [35:0]     upd_patt = '0;
    logic [35:0]     upd_mask = '0;
    logic            upd_del = 1'b0;
    logic            upd_busy;
    logic            upd_done;
    logic            lk_valid = 1'b0;
    logic            lk_ready;
    logic [35:0]     lk_patt = '0;
    logic [NB-1:0]   ram_wen;
    logic [35:0]     ram_addr;
    logic [SA-1:0]   ram_din;
    logic [NB*SA-1:0] ram_dout;

    logic [SA-1:0]   mem [NB][512];
    logic            fill_req = 1'b0;
    logic [SA-1:0]   fill_val = '0;

    int total = 0;
    int bad   = 0;

    logic [8:0] pj [4] = '{9'h189, 9'h0B3, 9'h0D1, 9'h024};
    localparam logic [35:0] PATT = 36'h123456789;
    localparam logic [35:0] KEY  = 36'hA5C3F0E1D;

`ifdef TCAM_UPD_WRSKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    tcam_upd_ctrl #(.DEPTH(512), .WIDTH(36), .L(4), .N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
        .upd_patt(upd_patt), .upd_mask(upd_mask), .upd_del(upd_del),
        .upd_busy(upd_busy), .upd_done(upd_done),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_patt(lk_patt),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int bk = 0; bk < NB; bk++)
                for (int v = 0; v < 512; v++) mem[bk][v] <= fill_val;
        end else begin
            for (int bk = 0; bk < NB; bk++) begin
                ram_dout[bk*SA +: SA] <= mem[bk][ram_addr[(bk%4)*SW +: SW]];
                if (ram_wen[bk]) mem[bk][ram_addr[(bk%4)*SW +: SW]] <= ram_din;
            end
        end
    end

    task automatic fill(input logic [SA-1:0] val);
        @(negedge clk);
        fill_val = val;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic do_update(input logic [8:0] a, input logic [35:0] p, input logic [35:0] m,
                             input logic d, output logic rdy, output int lat, output int wr);
        @(negedge clk);
        upd_addr = a; upd_patt = p; upd_mask = m; upd_del = d;
        upd_valid = 1'b1; lk_valid = 1'b0;
        #1 rdy = upd_ready;
        lat = 0; wr = 0;
        do begin
            @(negedge clk);
            upd_valid = 1'b0;
            #1 lat++;
            if (ram_wen !== '0) wr++;
        end while (upd_done !== 1'b1 && lat < 7000);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; upd_valid = 1'b1; lk_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rst_upd_ready: got %b want 0", upd_ready); end
        total++; if (lk_ready !== 1'b0) begin bad++; $display("FAIL rst_lk_ready: got %b want 0", lk_ready); end
        total++; if (upd_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", upd_busy); end
        total++; if (upd_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", upd_done); end
        total++; if (ram_wen !== '0) begin bad++; $display("FAIL rst_wen: got %h want 0", ram_wen); end
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
        total++; if (ram_din !== '0) begin bad++; $display("FAIL rst_din: got %h want 0", ram_din); end
        @(negedge clk);
        upd_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL idle_upd_ready: got %b want 1", upd_ready); end
        total++; if (ram_addr !== '0 || ram_din !== '0 || ram_wen !== '0)
            begin bad++; $display("FAIL idle_ram_quiet: addr=%h din=%h wen=%h want 0", ram_addr, ram_din, ram_wen); end
        @(negedge clk);
        lk_valid = 1'b1; lk_patt = KEY;
        #1;
        total++; if (lk_ready !== 1'b1) begin bad++; $display("FAIL idle_lk_ready: got %b want 1", lk_ready); end
        total++; if (ram_addr !== KEY) begin bad++; $display("FAIL idle_lk_addr: got %h want %h", ram_addr, KEY); end
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL idle_lk_upd_ready: got %b want 0", upd_ready); end
        @(negedge clk);
        lk_valid = 1'b0;
    endtask

    task automatic test_insert;
        logic rdy; int lat, wr, errs; logic [SA-1:0] ex;
        fill('0);
        do_update(9'd130, PATT, '0, 1'b0, rdy, lat, wr);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ins_accept: got %b want 1", rdy); end
        total++; if (lat != 6145) begin bad++; $display("FAIL ins_latency: got %0d want 6145", lat); end
        total++; if (wr != (SKIP ? 4 : 2048)) begin bad++; $display("FAIL ins_writes: got %0d want %0d", wr, SKIP ? 4 : 2048); end
        for (int bk = 0; bk < NB; bk++) begin
            errs = 0;
            for (int v = 0; v < 512; v++) begin
                ex = '0;
                if (bk / 4 == 1 && 9'(v) == pj[bk%4]) ex[2] = 1'b1;
                if (mem[bk][v] !== ex) errs++;
            end
            total++; if (errs != 0) begin bad++; $display("FAIL ins_bank%0d: %0d wrong words, want 0", bk, errs); end
        end
        // Same insert again: content is already final, so only the skip build elides writes.
        do_update(9'd130, PATT, '0, 1'b0, rdy, lat, wr);
        total++; if (lat != 6145) begin bad++; $display("FAIL rerun_latency: got %0d want 6145", lat); end
        total++; if (wr != (SKIP ? 0 : 2048)) begin bad++; $display("FAIL rerun_writes: got %0d want %0d", wr, SKIP ? 0 : 2048); end
        errs = 0;
        for (int j = 0; j < 4; j++)
            for (int v = 0; v < 512; v++)
                if (mem[4+j][v] !== ((9'(v) == pj[j]) ? 128'h4 : 128'h0)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL rerun_content: %0d wrong words, want 0", errs); end
    endtask

    task automatic test_ternary;
        logic rdy; int lat, wr, errs; logic [SA-1:0] ex;
        fill('0);
        do_update(9'd5, 36'h0, 36'h0000001FF, 1'b0, rdy, lat, wr);
        total++; if (lat != 6145) begin bad++; $display("FAIL tern_latency: got %0d want 6145", lat); end
        total++; if (wr != (SKIP ? 515 : 2048)) begin bad++; $display("FAIL tern_writes: got %0d want %0d", wr, SKIP ? 515 : 2048); end
        for (int bk = 0; bk < 4; bk++) begin
            errs = 0;
            for (int v = 0; v < 512; v++) begin
                ex = '0;
                if (bk == 0 || v == 0) ex[5] = 1'b1;
                if (mem[bk][v] !== ex) errs++;
            end
            total++; if (errs != 0) begin bad++; $display("FAIL tern_bank%0d: %0d wrong words, want 0", bk, errs); end
        end
        errs = 0;
        for (int bk = 4; bk < NB; bk++)
            for (int v = 0; v < 512; v++) if (mem[bk][v] !== '0) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL tern_other_banks: %0d wrong words, want 0", errs); end
    endtask

    task automatic test_delete;
        logic rdy; int lat, wr, errs; logic [SA-1:0] ex;
        fill('1);
        do_update(9'd130, PATT, '0, 1'b0, rdy, lat, wr);
        total++; if (wr != (SKIP ? 2044 : 2048)) begin bad++; $display("FAIL ins1_writes: got %0d want %0d", wr, SKIP ? 2044 : 2048); end
        errs = 0;
        for (int j = 0; j < 4; j++)
            for (int v = 0; v < 512; v++) begin
                ex = '1;
                ex[2] = (9'(v) == pj[j]);
                if (mem[4+j][v] !== ex) errs++;
            end
        total++; if (errs != 0) begin bad++; $display("FAIL ins1_content: %0d wrong words, want 0", errs); end
        do_update(9'd130, PATT, '0, 1'b1, rdy, lat, wr);
        total++; if (lat != 6145) begin bad++; $display("FAIL del_latency: got %0d want 6145", lat); end
        total++; if (wr != (SKIP ? 4 : 2048)) begin bad++; $display("FAIL del_writes: got %0d want %0d", wr, SKIP ? 4 : 2048); end
        errs = 0;
        for (int bk = 0; bk < NB; bk++)
            for (int v = 0; v < 512; v++) begin
                ex = '1;
                if (bk / 4 == 1) ex[2] = 1'b0;
                if (mem[bk][v] !== ex) errs++;
            end
        total++; if (errs != 0) begin bad++; $display("FAIL del_content: %0d wrong words, want 0", errs); end
    endtask

    task automatic test_lookup_stall;
        logic rdy; int lat, cyc, left, grants, gerr, probe_at, probes, perr, errs; bit started;
        fill('0);
        @(negedge clk);
        upd_addr = 9'd130; upd_patt = PATT; upd_mask = '0; upd_del = 1'b0; upd_valid = 1'b1;
        #1 rdy = upd_ready;
        lat = 0; left = 0; grants = 0; gerr = 0; probe_at = 0; probes = 0; perr = 0; started = 0;
        do begin
            @(negedge clk);
            upd_valid = 1'b0;
            cyc = lat + 1;
            lk_patt = KEY;
            lk_valid = (left > 0) || (probe_at != 0 && (cyc == probe_at || cyc == probe_at + 1));
            #1 lat = cyc;
            if (left > 0) begin
                grants++; left--;
                if (lk_ready !== 1'b1 || ram_wen !== '0 || ram_addr !== KEY) gerr++;
            end else if (lk_valid) begin
                probes++;
                if (lk_ready !== 1'b0) perr++;
            end else if (ram_wen !== '0) begin
                if (!started && lat > 200) begin started = 1; left = 10; end
                else if (started && probe_at == 0) probe_at = lat + 2;
            end
        end while (upd_done !== 1'b1 && lat < 7000);
        lk_valid = 1'b0;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL stall_accept: got %b want 1", rdy); end
        total++; if (grants != 10 || gerr != 0) begin bad++; $display("FAIL stall_grants: got %0d grants %0d bad, want 10 grants 0 bad", grants, gerr); end
        total++; if (probes != 2 || perr != 0) begin bad++; $display("FAIL cap_wr_no_grant: got %0d probes %0d granted, want 2 probes 0 granted", probes, perr); end
        total++; if (lat != 6155) begin bad++; $display("FAIL stall_latency: got %0d want 6155", lat); end
        errs = 0;
        for (int j = 0; j < 4; j++)
            for (int v = 0; v < 512; v++)
                if (mem[4+j][v] !== ((9'(v) == pj[j]) ? 128'h4 : 128'h0)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL stall_content: %0d wrong words, want 0", errs); end
    endtask

    task automatic test_collision;
        int lat, cerr, rerr, errs;
        fill('0);
        cerr = 0;
        @(negedge clk);
        upd_addr = 9'd130; upd_patt = PATT; upd_mask = '0; upd_del = 1'b0;
        upd_valid = 1'b1; lk_valid = 1'b1; lk_patt = KEY;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (lk_ready !== 1'b1 || upd_ready !== 1'b0 || upd_busy !== 1'b0) cerr++;
            @(negedge clk);
        end
        total++; if (cerr != 0) begin bad++; $display("FAIL coll_lookup_wins: %0d bad cycles, want 0", cerr); end
        lk_valid = 1'b0;
        #1;
        total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL coll_accept: got %b want 1", upd_ready); end
        // Keep requesting a different entry while busy; it must be ignored.
        lat = 0; rerr = 0;
        do begin
            @(negedge clk);
            upd_addr = 9'd0;
            if (lat >= 6000) upd_valid = 1'b0;
            #1 lat++;
            if (upd_done !== 1'b1 && (upd_ready !== 1'b0 || upd_busy !== 1'b1)) rerr++;
        end while (upd_done !== 1'b1 && lat < 7000);
        upd_valid = 1'b0;
        total++; if (rerr != 0) begin bad++; $display("FAIL coll_busy_ignore: %0d bad cycles, want 0", rerr); end
        total++; if (lat != 6145) begin bad++; $display("FAIL coll_latency: got %0d want 6145", lat); end
        errs = 0;
        for (int bk = 0; bk < 8; bk++)
            for (int v = 0; v < 512; v++)
                if (mem[bk][v] !== ((bk / 4 == 1 && 9'(v) == pj[bk%4]) ? 128'h4 : 128'h0)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL coll_content: %0d wrong words, want 0", errs); end
    endtask

    task automatic test_reset_mid;
        int lat, qerr;
        @(negedge clk);
        upd_addr = 9'd130; upd_patt = PATT; upd_mask = '0; upd_del = 1'b0; upd_valid = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            upd_valid = 1'b0;
            #1 lat++;
        end
        total++; if (upd_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", upd_busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (upd_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", upd_busy); end
        total++; if (ram_wen !== '0) begin bad++; $display("FAIL mid_rst_wen: got %h want 0", ram_wen); end
        qerr = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (ram_wen !== '0 || upd_busy !== 1'b0 || upd_done !== 1'b0) qerr++;
        end
        total++; if (qerr != 0) begin bad++; $display("FAIL mid_rst_quiet: %0d bad cycles, want 0", qerr); end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_insert();
        test_ternary();
        test_delete();
        test_lookup_stall();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
